// File: rtl/die_draw_scheduler.sv
// die_draw_scheduler
//   Shares one die sprite ROM and palette path between NUM_DICE dice.
//   For each pixel it picks the lowest-index die covering it and builds the
//   sprite ROM address. It returns the palette index two cycles later, aligned
//   to the one-cycle ROM read.
//
//   Optional feature macro: DIE_ROLL_EN
//     defined   : per-die roll animation FSMs (roll_req / rolling active)
//     undefined : roll_req ignored, rolling = 0, displayed face = shadow face
//
// Ports
//   vga_clk      pixel clock, all state on posedge
//   reset_n      asynchronous active-low reset
//   DrawX/DrawY  current pixel column / row
//   blank        1 = active video
//   frame_start  one-cycle pulse at start of vertical blank
//   die_x/die_y  per-die left / top edge, 10 bits each
//   die_face     per-die target face 0..5 (6,7 read as 0), 3 bits each
//   die_en       per-die visible
//   roll_req     per-die one-cycle roll request
//   rom_address  sprite ROM address (registered)
//   rom_q        ROM data for the registered address
//   pix_index    palette index of the output pixel (0 when not valid)
//   pix_valid    output pixel is an opaque die pixel
//   hit_id       die owning pix_index (0 when not valid)
//   rolling      per-die roll animation active
module die_draw_scheduler #(
   parameter int NUM_DICE    = 4,
   parameter int SPR_W       = 100,
   parameter int SPR_H       = 100,
   parameter int ROM_AW      = 16,
   parameter int TRANSP_IDX  = 0,
   parameter int ROLL_FRAMES = 30,
   parameter int ROLL_STEP   = 3
) (
   input  logic                     vga_clk,
   input  logic                     reset_n,
   input  logic [9:0]               DrawX,
   input  logic [9:0]               DrawY,
   input  logic                     blank,
   input  logic                     frame_start,
   input  logic [10*NUM_DICE-1:0]   die_x,
   input  logic [10*NUM_DICE-1:0]   die_y,
   input  logic [3*NUM_DICE-1:0]    die_face,
   input  logic [NUM_DICE-1:0]      die_en,
   input  logic [NUM_DICE-1:0]      roll_req,
   output logic [ROM_AW-1:0]        rom_address,
   input  logic [3:0]               rom_q,
   output logic [3:0]               pix_index,
   output logic                     pix_valid,
   output logic [2:0]               hit_id,
   output logic [NUM_DICE-1:0]      rolling
);

   function automatic logic [2:0] face_clip(input logic [2:0] f);
      return (f > 3'd5) ? 3'd0 : f;
   endfunction

   // Position / enable shadows: only change on frame_start so a frame never tears.
   logic [10*NUM_DICE-1:0] sx_q, sx_d, sy_q, sy_d;
   logic [NUM_DICE-1:0]    sen_q, sen_d;
   logic [3*NUM_DICE-1:0]  face_tgt;
   logic [3*NUM_DICE-1:0]  face_disp;

   for (genvar g = 0; g < NUM_DICE; g++) begin : g_tgt
      assign face_tgt[3*g +: 3] = face_clip(die_face[3*g +: 3]);
   end

   always_comb begin
      sx_d  = frame_start ? die_x  : sx_q;
      sy_d  = frame_start ? die_y  : sy_q;
      sen_d = frame_start ? die_en : sen_q;
   end

   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         sx_q  <= '0;
         sy_q  <= '0;
         sen_q <= '0;
      end else begin
         sx_q  <= sx_d;
         sy_q  <= sy_d;
         sen_q <= sen_d;
      end
   end

`ifdef DIE_ROLL_EN
   localparam int FC_W = (ROLL_FRAMES > 1) ? $clog2(ROLL_FRAMES) : 1;
   localparam int SC_W = (ROLL_STEP > 1) ? $clog2(ROLL_STEP) : 1;

   // fd_q is the displayed face; in IDLE it is reloaded from the target face
   // at every frame_start, so it doubles as the face shadow.
   logic [NUM_DICE-1:0]      pend_q, pend_d, roll_q, roll_d;
   logic [FC_W*NUM_DICE-1:0] fc_q, fc_d;
   logic [SC_W*NUM_DICE-1:0] sc_q, sc_d;
   logic [3*NUM_DICE-1:0]    fd_q, fd_d;

   always_comb begin
      pend_d = pend_q;
      roll_d = roll_q;
      fc_d   = fc_q;
      sc_d   = sc_q;
      fd_d   = fd_q;
      for (int i = 0; i < NUM_DICE; i++) begin
         if (frame_start) begin
            if (pend_q[i]) begin
               // A pending request starts (or restarts) the roll from frame 0.
               roll_d[i]             = 1'b1;
               fc_d[FC_W*i +: FC_W]  = '0;
               sc_d[SC_W*i +: SC_W]  = '0;
            end else if (roll_q[i]) begin
               if (fc_q[FC_W*i +: FC_W] == FC_W'(ROLL_FRAMES - 1)) begin
                  fd_d[3*i +: 3] = face_tgt[3*i +: 3];
                  roll_d[i]      = 1'b0;
               end else begin
                  fc_d[FC_W*i +: FC_W] = fc_q[FC_W*i +: FC_W] + 1'b1;
                  if (sc_q[SC_W*i +: SC_W] == SC_W'(ROLL_STEP - 1)) begin
                     sc_d[SC_W*i +: SC_W] = '0;
                     fd_d[3*i +: 3] = (fd_q[3*i +: 3] == 3'd5) ? 3'd0 : fd_q[3*i +: 3] + 3'd1;
                  end else begin
                     sc_d[SC_W*i +: SC_W] = sc_q[SC_W*i +: SC_W] + 1'b1;
                  end
               end
            end else begin
               fd_d[3*i +: 3] = face_tgt[3*i +: 3];
            end
            pend_d[i] = 1'b0;
         end
         // A request on a frame_start cycle is kept for the next frame_start.
         if (roll_req[i]) begin
            pend_d[i] = 1'b1;
         end
      end
   end

   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         pend_q <= '0;
         roll_q <= '0;
         fc_q   <= '0;
         sc_q   <= '0;
         fd_q   <= '0;
      end else begin
         pend_q <= pend_d;
         roll_q <= roll_d;
         fc_q   <= fc_d;
         sc_q   <= sc_d;
         fd_q   <= fd_d;
      end
   end

   assign face_disp = fd_q;
   assign rolling   = roll_q;
`else
   logic [3*NUM_DICE-1:0] sf_q, sf_d;
   logic                  unused_roll;
   logic [31:0]           unused_roll_cfg;

   assign unused_roll     = ^roll_req;
   assign unused_roll_cfg = 32'(ROLL_FRAMES) ^ 32'(ROLL_STEP);

   always_comb begin
      sf_d = frame_start ? face_tgt : sf_q;
   end

   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         sf_q <= '0;
      end else begin
         sf_q <= sf_d;
      end
   end

   assign face_disp = sf_q;
   assign rolling   = '0;
`endif

   // Per-die hit test and sprite address, local offsets in 11-bit signed.
   logic [NUM_DICE-1:0]        die_hit;
   logic [ROM_AW*NUM_DICE-1:0] die_addr;

   for (genvar g = 0; g < NUM_DICE; g++) begin : g_die
      logic signed [10:0] lx, ly;
      assign lx = $signed({1'b0, DrawX}) - $signed({1'b0, sx_q[10*g +: 10]});
      assign ly = $signed({1'b0, DrawY}) - $signed({1'b0, sy_q[10*g +: 10]});
      assign die_hit[g] = sen_q[g] && (int'(lx) >= 0) && (int'(lx) < SPR_W)
                                   && (int'(ly) >= 0) && (int'(ly) < SPR_H);
      assign die_addr[ROM_AW*g +: ROM_AW] =
         ROM_AW'(32'(face_disp[3*g +: 3]) * 32'(SPR_W * SPR_H)
                 + 32'(ly[9:0]) * 32'(SPR_W) + 32'(lx[9:0]));
   end

   logic [ROM_AW-1:0] rom_address_q, rom_address_d;
   logic              hit_q, hit_d;
   logic [2:0]        win_q, win_d;
   logic              blank_q, blank_d;
   logic [3:0]        pix_index_q, pix_index_d;
   logic              pix_valid_q, pix_valid_d;
   logic [2:0]        hit_id_q, hit_id_d;

   always_comb begin
      // Stage 1: lowest-index hit wins; a transparent winner still owns the pixel.
      hit_d         = 1'b0;
      win_d         = '0;
      rom_address_d = '0;
      for (int i = NUM_DICE - 1; i >= 0; i--) begin
         if (die_hit[i]) begin
            hit_d         = 1'b1;
            win_d         = 3'(i);
            rom_address_d = die_addr[ROM_AW*i +: ROM_AW];
         end
      end
      blank_d = blank;

      // Stage 2: ROM data for the stage-1 address is present now.
      pix_valid_d = hit_q && blank_q && (rom_q != 4'(TRANSP_IDX));
      pix_index_d = pix_valid_d ? rom_q : 4'd0;
      hit_id_d    = pix_valid_d ? win_q : 3'd0;
   end

   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         rom_address_q <= '0;
         hit_q         <= 1'b0;
         win_q         <= '0;
         blank_q       <= 1'b0;
         pix_index_q   <= '0;
         pix_valid_q   <= 1'b0;
         hit_id_q      <= '0;
      end else begin
         rom_address_q <= rom_address_d;
         hit_q         <= hit_d;
         win_q         <= win_d;
         blank_q       <= blank_d;
         pix_index_q   <= pix_index_d;
         pix_valid_q   <= pix_valid_d;
         hit_id_q      <= hit_id_d;
      end
   end

   assign rom_address = rom_address_q;
   assign pix_index   = pix_index_q;
   assign pix_valid   = pix_valid_q;
   assign hit_id      = hit_id_q;

endmodule
